// File: rtl/note_tone_gen_if.sv
// Note/tone interface: the decoder drives the key state, the tone generator returns its outputs.
interface note_tone_gen_if;
  logic [3:0] note_1;
  logic [3:0] note_2;
  logic       multi;
  logic       key_on;
  logic       tone_o;
  logic [3:0] note_o;
  logic       arp_sel_o;
  logic       playing_o;

  modport master (
    output note_1, note_2, multi, key_on,
    input  tone_o, note_o, arp_sel_o, playing_o
  );

  modport slave (
    input  note_1, note_2, multi, key_on,
    output tone_o, note_o, arp_sel_o, playing_o
  );
endinterface

// File: rtl/note_tone_gen.sv
// Square-wave tone generator. Plays note_1 while keys are held and arpeggiates between
// note_1 and note_2 when more than one key is down. Codes 14/15 are silent.
module note_tone_gen #(
  parameter int unsigned ARP_TICKS = 1_000_000,
  parameter int unsigned SIM_SCALE = 0
) (
  input  logic            clk,
  input  logic            n_rst,
  note_tone_gen_if.slave  bus
);

  localparam int unsigned ArpW = $clog2(ARP_TICKS);

  typedef enum logic [1:0] {StIdle, StPlay1, StPlay2} state_e;

  state_e            state_q;
  logic [14:0]       div_cnt_q;
  logic [ArpW-1:0]   arp_cnt_q;
  logic              tone_q;
  logic [3:0]        note_q;
  logic              arp_sel_q;
  logic              playing_q;

  // Half-period in clocks for a note code, scaled down for simulation, never below 1.
  function automatic logic [14:0] half_of(input logic [3:0] code);
    logic [14:0] rom;
    logic [14:0] scaled;
    case (code)
      4'd0:    rom = 15'd19111;
      4'd1:    rom = 15'd18039;
      4'd2:    rom = 15'd17026;
      4'd3:    rom = 15'd16070;
      4'd4:    rom = 15'd15169;
      4'd5:    rom = 15'd14317;
      4'd6:    rom = 15'd13514;
      4'd7:    rom = 15'd12755;
      4'd8:    rom = 15'd12039;
      4'd9:    rom = 15'd11364;
      4'd10:   rom = 15'd10726;
      4'd11:   rom = 15'd10124;
      4'd12:   rom = 15'd9556;
      4'd13:   rom = 15'd9019;
      default: rom = 15'd1;
    endcase
    scaled = rom >> SIM_SCALE;
    return (scaled == 15'd0) ? 15'd1 : scaled;
  endfunction

  logic [3:0]  cur_in;
  logic [3:0]  other_in;
  logic [14:0] half;
  logic        arp_last;
  logic        arp_switch;

  // Decode the note being tracked, the divider limit and the arpeggio switch condition.
  always_comb begin
    cur_in     = (state_q == StPlay2) ? bus.note_2 : bus.note_1;
    other_in   = (state_q == StPlay1) ? bus.note_2 : bus.note_1;
    half       = half_of(note_q);
    arp_last   = (arp_cnt_q == ArpW'(ARP_TICKS - 1));
    // Multi drop outranks arp expiry in PLAY_2; both lead back to PLAY_1.
    arp_switch = ((state_q == StPlay1) && bus.multi && arp_last) ||
                 ((state_q == StPlay2) && (!bus.multi || arp_last));
  end

  // FSM, divider, arpeggio counter and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      div_cnt_q <= '0;
      arp_cnt_q <= '0;
      tone_q    <= 1'b0;
      note_q    <= 4'd0;
      arp_sel_q <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.key_on) begin
            state_q   <= StPlay1;
            note_q    <= bus.note_1;
            tone_q    <= (bus.note_1 < 4'd14);
            playing_q <= 1'b1;
            arp_sel_q <= 1'b0;
            div_cnt_q <= '0;
            arp_cnt_q <= '0;
          end
        end
        default: begin
          if (!bus.key_on) begin
            // Release wins over every other event; note_q keeps the last code.
            state_q   <= StIdle;
            tone_q    <= 1'b0;
            playing_q <= 1'b0;
            arp_sel_q <= 1'b0;
            div_cnt_q <= '0;
            arp_cnt_q <= '0;
          end else if (arp_switch) begin
            state_q   <= (state_q == StPlay1) ? StPlay2 : StPlay1;
            arp_sel_q <= (state_q == StPlay1);
            note_q    <= other_in;
            tone_q    <= (other_in < 4'd14);
            div_cnt_q <= '0;
            arp_cnt_q <= '0;
          end else begin
            arp_cnt_q <= bus.multi ? arp_cnt_q + ArpW'(1) : '0;
            if (cur_in != note_q) begin
              // Follow a live note change without disturbing the arpeggio timing.
              note_q    <= cur_in;
              tone_q    <= (cur_in < 4'd14);
              div_cnt_q <= '0;
            end else if (note_q >= 4'd14) begin
              tone_q    <= 1'b0;
              div_cnt_q <= '0;
            end else if (div_cnt_q == half - 15'd1) begin
              div_cnt_q <= '0;
              tone_q    <= ~tone_q;
            end else begin
              div_cnt_q <= div_cnt_q + 15'd1;
            end
          end
        end
      endcase
    end
  end

  assign bus.tone_o    = tone_q;
  assign bus.note_o    = note_q;
  assign bus.arp_sel_o = arp_sel_q;
  assign bus.playing_o = playing_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Scoreboard bench for note_tone_gen: stimulus queues expected outputs tagged with the clock
// edge they belong to; the monitor compares them on the following falling edge.
module tb_note_tone_gen;

  logic clk;
  logic n_rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  note_tone_gen_if bus ();

  note_tone_gen #(
    .ARP_TICKS (32),
    .SIM_SCALE (10)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         stamp;
    logic [6:0] exp;  // {tone, note[3:0], arp_sel, playing}
  } item_t;

  item_t q[$];
  item_t it;
  logic [6:0] got;

  // Monitor: compare every queued expectation whose edge has arrived.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].stamp <= cyc) begin
      it = q.pop_front();
      got = {bus.tone_o, bus.note_o, bus.arp_sel_o, bus.playing_o};
      checks++;
      if (it.stamp < cyc) begin
        errors++;
        $display("FAIL %s: expectation for edge %0d not checked in time (now %0d)",
                 it.name, it.stamp, cyc);
      end else if (got !== it.exp) begin
        errors++;
        $display("FAIL %s @edge %0d: got tone=%b note=%0d arp=%b play=%b, want tone=%b note=%0d arp=%b play=%b",
                 it.name, it.stamp, got[6], got[5:2], got[1], got[0],
                 it.exp[6], it.exp[5:2], it.exp[1], it.exp[0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input int stamp, input logic tone,
                      input logic [3:0] note, input logic arp, input logic play);
    q.push_back('{name, stamp, {tone, note, arp, play}});
  endtask

  // Expected square wave starting at its load edge: high for half cycles, then low, ...
  task automatic push_tone(input string name, input int stamp0, input int n,
                           input logic [3:0] note, input logic arp, input int half);
    for (int j = 0; j < n; j++) begin
      push(name, stamp0 + j, ((j / half) % 2) == 0, note, arp, 1'b1);
    end
  endtask

  int s, s3, e, s5, c;

  initial begin
    n_rst      = 1'b0;
    bus.key_on = 1'b0;
    bus.multi  = 1'b0;
    bus.note_1 = 4'd0;
    bus.note_2 = 4'd0;
    step();
    push("reset", cyc, 1'b0, 4'd0, 1'b0, 1'b0);
    step();
    n_rst = 1'b1;
    step();

    // Single key A4: HALF=11, then release.
    bus.key_on = 1'b1;
    bus.note_1 = 4'd9;
    s = cyc + 1;
    push_tone("single_a4", s, 100, 4'd9, 1'b0, 11);
    repeat (100) step();
    bus.key_on = 1'b0;
    push("release", s + 100, 1'b0, 4'd9, 1'b0, 1'b0);
    step();
    step();

    // Arpeggio 13 (HALF=8) / 0 (HALF=18), 32 cycles each.
    bus.key_on = 1'b1;
    bus.multi  = 1'b1;
    bus.note_1 = 4'd13;
    bus.note_2 = 4'd0;
    s = cyc + 1;
    push_tone("arp_p1", s, 32, 4'd13, 1'b0, 8);
    push_tone("arp_p2", s + 32, 32, 4'd0, 1'b1, 18);
    repeat (64) step();

    // Now in PLAY_2 with arp_cnt=31: multi drop returns to PLAY_1.
    bus.multi = 1'b0;
    s3 = cyc + 1;
    e  = s3 + 41;
    push_tone("multi_drop", s3, 41, 4'd13, 1'b0, 8);
    push_tone("rearp_p2", e, 32, 4'd0, 1'b1, 18);
    push_tone("rearp_p1", e + 32, 32, 4'd13, 1'b0, 8);
    push("release_vs_arp", e + 64, 1'b0, 4'd13, 1'b0, 1'b0);
    repeat (10) step();
    // arp_cnt was held at 0 while multi=0, so the next switch is 31 edges away.
    bus.multi = 1'b1;
    repeat (95) step();
    bus.key_on = 1'b0;  // coincides with arp_cnt=31 in PLAY_1
    step();
    step();

    // Live note change 9 -> 4 mid-period.
    bus.multi  = 1'b0;
    bus.key_on = 1'b1;
    bus.note_1 = 4'd9;
    s5 = cyc + 1;
    c  = s5 + 6;
    push_tone("pre_change", s5, 6, 4'd9, 1'b0, 11);
    push_tone("note_change", c, 39, 4'd4, 1'b0, 14);
    repeat (6) step();
    bus.note_1 = 4'd4;
    repeat (40) step();

    // Asynchronous reset mid-tone, checked before any further rising edge.
    #1;
    n_rst = 1'b0;
    push("async_reset", cyc, 1'b0, 4'd0, 1'b0, 1'b0);
    push("reset_held", cyc + 1, 1'b0, 4'd0, 1'b0, 1'b0);
    step();
    n_rst      = 1'b1;
    bus.note_1 = 4'd15;
    for (int j = 1; j <= 30; j++) begin
      push("invalid_code", cyc + j, 1'b0, 4'd15, 1'b0, 1'b1);
    end
    repeat (31) step();
    bus.key_on = 1'b0;

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 50 && q.size() > 0; k++) step();
    step();
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations left unchecked", q.size());
      errors += q.size();
      checks += q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
